// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch controller
// Purpose: FSM state encoding, BCD digit width and blank_mask bit positions.
// Ports: none (package).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // blank_mask bit positions, most significant digit at the top
  localparam int BLANK_MIN_TENS = 3;
  localparam int BLANK_MIN_ONES = 2;
  localparam int BLANK_SEC_TENS = 1;
  localparam int BLANK_SEC_ONES = 0;

  localparam logic [3:0] BLANK_MIN =
    (4'b0001 << BLANK_MIN_TENS) | (4'b0001 << BLANK_MIN_ONES);
  localparam logic [3:0] BLANK_SEC =
    (4'b0001 << BLANK_SEC_TENS) | (4'b0001 << BLANK_SEC_ONES);

endpackage

// File: rtl/bcd_mod60.sv
// rtl/bcd_mod60.sv - two-digit BCD counter wrapping at MAX
// Purpose: holds one time field (tens/ones BCD), counts on inc, clears on clr.
// Ports: clk, rst (sync, active-high), clr, inc -> tens, ones (BCD),
//        carry (combinational, high when inc hits the terminal value).
module bcd_mod60
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(MAX / 10);
  localparam logic [DIGIT_W-1:0] ONES_MAX = DIGIT_W'(MAX % 10);

  logic at_max;

  assign at_max = (tens == TENS_MAX) && (ones == ONES_MAX);
  // Combinational so the next field can step on the same edge as this one.
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == DIGIT_W'(9)) begin
        tens <= tens + DIGIT_W'(1);
        ones <= '0;
      end else begin
        ones <= ones + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/adjust stopwatch with BCD outputs
// Purpose: FSM (PAUSED/RUN/ADJUST), blink phase, carry gating between fields.
// Ports: clk, rst (sync, active-high), one_hz_tick, two_hz_tick, blink_tick,
//        pause_pulse, clr_pulse, adj_sw, sel_sw -> min_tens, min_ones,
//        sec_tens, sec_ones (BCD), blank_mask[3:0], running.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               one_hz_tick,
  input  logic               two_hz_tick,
  input  logic               blink_tick,
  input  logic               pause_pulse,
  input  logic               clr_pulse,
  input  logic               adj_sw,
  input  logic               sel_sw,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [3:0]         blank_mask,
  output logic               running
);

  state_t state, state_next;
  logic   blink_phase, blink_next;
  logic   sec_inc, min_inc, sec_carry;
  logic   min_carry_unused;

  always_comb begin
    state_next = state;
    sec_inc    = 1'b0;
    min_inc    = 1'b0;
    blink_next = blink_phase ^ blink_tick;

    // adj_sw overrides pause_pulse from any state
    if (adj_sw) begin
      state_next = ADJUST;
    end else begin
      unique case (state)
        PAUSED:  if (pause_pulse) state_next = RUN;
        RUN:     if (pause_pulse) state_next = PAUSED;
        default: state_next = PAUSED;
      endcase
    end

    // Seconds carry reaches minutes only while running; adjust edits one field.
    unique case (state)
      RUN: begin
        sec_inc = one_hz_tick;
        min_inc = sec_carry;
      end
      ADJUST: begin
        sec_inc = two_hz_tick && sel_sw;
        min_inc = two_hz_tick && !sel_sw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PAUSED;
      blink_phase <= 1'b0;
      running     <= 1'b0;
      blank_mask  <= '0;
    end else begin
      state       <= state_next;
      blink_phase <= blink_next;
      running     <= (state_next == RUN);
      blank_mask  <= (state_next == ADJUST && blink_next)
                     ? (sel_sw ? BLANK_SEC : BLANK_MIN) : 4'b0000;
    end
  end

  bcd_mod60 #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_pulse),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  // Full-time wrap to 00:00 is silent, so the minutes carry goes nowhere.
  bcd_mod60 #(.MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_pulse),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry_unused)
  );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int SMAX = 59;
  localparam int MMAX = 59;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       one_hz_tick = 1'b0, two_hz_tick = 1'b0, blink_tick = 1'b0;
  logic       pause_pulse = 1'b0, clr_pulse = 1'b0;
  logic       adj_sw = 1'b0, sel_sw = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank_mask;
  logic       running;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: whole-number minutes/seconds, mode 0=paused 1=run 2=adjust
  int         m_min = 0, m_sec = 0, m_mode = 0;
  bit         m_blink = 1'b0;
  logic       m_running = 1'b0;
  logic [3:0] m_mask = 4'b0000;

  stopwatch_ctrl #(.SEC_MAX(SMAX), .MIN_MAX(MMAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .one_hz_tick (one_hz_tick),
    .two_hz_tick (two_hz_tick),
    .blink_tick  (blink_tick),
    .pause_pulse (pause_pulse),
    .clr_pulse   (clr_pulse),
    .adj_sw      (adj_sw),
    .sel_sw      (sel_sw),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .blank_mask  (blank_mask),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int nmode;
    int t;
    if (rst) begin
      m_min = 0; m_sec = 0; nmode = 0; m_blink = 1'b0;
    end else begin
      if (adj_sw) nmode = 2;
      else if (m_mode == 2) nmode = 0;
      else if (pause_pulse) nmode = (m_mode == 1) ? 0 : 1;
      else nmode = m_mode;
      if (clr_pulse) begin
        m_min = 0; m_sec = 0;
      end else if (m_mode == 1 && one_hz_tick) begin
        t = (m_min * (SMAX + 1) + m_sec + 1) % ((MMAX + 1) * (SMAX + 1));
        m_min = t / (SMAX + 1);
        m_sec = t % (SMAX + 1);
      end else if (m_mode == 2 && two_hz_tick) begin
        if (sel_sw) m_sec = (m_sec + 1) % (SMAX + 1);
        else        m_min = (m_min + 1) % (MMAX + 1);
      end
      if (blink_tick) m_blink = !m_blink;
    end
    m_mode    = nmode;
    m_running = (nmode == 1);
    m_mask    = (!rst && nmode == 2 && m_blink) ? (sel_sw ? 4'b0011 : 4'b1100) : 4'b0000;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_min_tens"}, min_tens, 4'(m_min / 10));
    chk({tag, "_min_ones"}, min_ones, 4'(m_min % 10));
    chk({tag, "_sec_tens"}, sec_tens, 4'(m_sec / 10));
    chk({tag, "_sec_ones"}, sec_ones, 4'(m_sec % 10));
    chk({tag, "_blank_mask"}, blank_mask, m_mask);
    chk({tag, "_running"}, {3'b000, running}, {3'b000, m_running});
  endtask

  task automatic chk_time(input string tag, input int mm, input int ss);
    chk({tag, "_min_tens"}, min_tens, 4'(mm / 10));
    chk({tag, "_min_ones"}, min_ones, 4'(mm % 10));
    chk({tag, "_sec_tens"}, sec_tens, 4'(ss / 10));
    chk({tag, "_sec_ones"}, sec_ones, 4'(ss % 10));
  endtask

  task automatic chk_paused(input string tag);
    chk({tag, "_state"}, 4'(dut.state), 4'(PAUSED));
  endtask

  // Drive one cycle of pulses, advance the model, sample 1 time unit after the edge.
  task automatic pulse(input logic p, input logic c, input logic o, input logic t, input logic b);
    pause_pulse = p; clr_pulse = c; one_hz_tick = o; two_hz_tick = t; blink_tick = b;
    model_step();
    @(posedge clk);
    #1;
    pause_pulse = 1'b0; clr_pulse = 1'b0; one_hz_tick = 1'b0;
    two_hz_tick = 1'b0; blink_tick = 1'b0;
    check_all("cyc");
  endtask

  initial begin
    // reset
    rst = 1'b1;
    pulse(0, 0, 0, 0, 0);
    pulse(0, 0, 1, 1, 0);
    chk_time("rst", 0, 0);
    chk("rst_mask", blank_mask, 4'b0000);
    chk("rst_running", {3'b000, running}, 4'b0000);
    chk_paused("rst");
    rst = 1'b0;

    // run 61 seconds, then pause
    pulse(1, 0, 0, 0, 0);
    repeat (61) pulse(0, 0, 1, 0, 0);
    chk_time("run61", 1, 1);
    chk("run61_running", {3'b000, running}, 4'b0001);
    pulse(1, 0, 0, 0, 0);
    chk("pause_running", {3'b000, running}, 4'b0000);
    repeat (10) pulse(0, 0, 1, 0, 0);
    chk_time("paused10", 1, 1);

    // seconds adjust wraps without carry; one_hz ignored in ADJUST
    pulse(0, 1, 0, 0, 0);
    adj_sw = 1'b1; sel_sw = 1'b1;
    pulse(0, 0, 0, 0, 0);
    repeat (58) pulse(0, 0, 0, 1, 0);
    chk_time("adj58", 0, 58);
    repeat (3) pulse(0, 0, 0, 1, 0);
    chk_time("adjwrap", 0, 1);
    repeat (5) pulse(1, 0, 1, 0, 0);
    chk_time("adj_ign1hz", 0, 1);

    // preload 59:58 then run across the full wrap
    sel_sw = 1'b0;
    repeat (59) pulse(0, 0, 0, 1, 0);
    sel_sw = 1'b1;
    repeat (57) pulse(0, 0, 0, 1, 0);
    chk_time("preload", 59, 58);
    adj_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);
    chk_paused("adj_exit");
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 1, 0, 0);
    chk_time("r5959", 59, 59);
    pulse(0, 0, 1, 0, 0);
    chk_time("r0000", 0, 0);
    chk("wrap_running", {3'b000, running}, 4'b0001);

    // blink in minutes adjust
    adj_sw = 1'b1; sel_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1);
    chk("blink1", blank_mask, 4'b1100);
    pulse(0, 0, 0, 0, 1);
    chk("blink2", blank_mask, 4'b0000);
    pulse(0, 0, 0, 0, 1);
    chk("blink3", blank_mask, 4'b1100);
    adj_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);
    chk("blink_exit", blank_mask, 4'b0000);
    chk_paused("blink_exit");

    // clear beats a coincident tick at 12:34 in RUN
    pulse(0, 1, 0, 0, 0);
    adj_sw = 1'b1;
    pulse(0, 0, 0, 0, 0);
    repeat (12) pulse(0, 0, 0, 1, 0);
    sel_sw = 1'b1;
    repeat (34) pulse(0, 0, 0, 1, 0);
    adj_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk_time("pre_clr", 12, 34);
    pulse(0, 1, 1, 0, 0);
    chk_time("clr_tick", 0, 0);
    chk("clr_running", {3'b000, running}, 4'b0001);

    // reset in ADJUST at 07:07 with blink phase set
    pulse(0, 1, 0, 0, 0);
    adj_sw = 1'b1; sel_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);
    repeat (7) pulse(0, 0, 0, 1, 0);
    sel_sw = 1'b1;
    repeat (7) pulse(0, 0, 0, 1, 0);
    sel_sw = 1'b0;
    pulse(0, 0, 0, 0, logic'(!m_blink));
    chk("pre_rst_mask", blank_mask, 4'b1100);
    chk_time("pre_rst", 7, 7);
    rst = 1'b1;
    pulse(1, 1, 1, 1, 1);
    chk_time("adj_rst", 0, 0);
    chk("adj_rst_mask", blank_mask, 4'b0000);
    chk("adj_rst_running", {3'b000, running}, 4'b0000);
    chk_paused("adj_rst");
    rst = 1'b0; adj_sw = 1'b0;
    pulse(0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) adj_sw = ~adj_sw;
      if ($urandom_range(0, 15) == 0) sel_sw = ~sel_sw;
      pulse(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 49) == 0),
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
